// File: rtl/ht_scale_bcd_seq_pkg.sv
// Shared types and helpers for the sequential scaler / BCD converter.
// State encoding, glyph constant and per-digit add-3 step.
package ht_bcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCALE,
    ST_SIGN,
    ST_CONV,
    ST_STORE
  } state_e;

  localparam logic [3:0] MINUS_GLYPH = 4'hA;

  // Width of one gain/offset/bin lane.
  localparam int LANE_W = 16;
  // Width of one BCD digit.
  localparam int NIB_W  = 4;
  // Bits per channel in the DROP/DP vectors.
  localparam int FLD_W  = 2;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/ht_scale_bcd_seq_conv.sv
// Serial double-dabble engine: one input bit per cycle, MSB first.
// Shared across channels; reloaded for each conversion.
module bcd_serial_conv
  import ht_bcd_pkg::*;
#(
  parameter int BIN_W   = 16,
  parameter int BCD_DIG = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic [BIN_W-1:0]         mag_i,
  output logic [NIB_W*BCD_DIG-1:0] bcd_o,
  output logic                     last_o,
  output logic                     ready_o
);

  localparam int BCD_W = NIB_W * BCD_DIG;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Correct every digit that would overflow on the next doubling.
  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_DIG; i++) begin
      adj[NIB_W*i +: NIB_W] = add3(bcd_q[NIB_W*i +: NIB_W]);
    end
  end

  // Load a fresh magnitude or shift one bit into the digit string.
  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = mag_i;
      bcd_d = '0;
      cnt_d = CNT_W'(BIN_W);
    end else if (cnt_q != '0) begin
      bcd_d = (adj << 1) | BCD_W'(sh_q[BIN_W-1]);
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_o   = bcd_q;
  assign last_o  = (cnt_q == CNT_W'(1));
  assign ready_o = (cnt_q == '0);

endmodule

// File: rtl/ht_scale_bcd_seq.sv
// Time-multiplexed sensor scaler and BCD/7-seg formatter.
// One multiplier and one serial converter serve all channels.
module ht_scale_bcd_seq
  import ht_bcd_pkg::*;
#(
  parameter int         NCH      = 2,
  parameter int         CODE_W   = 16,
  parameter int         BIN_W    = 16,
  parameter int         BCD_DIG  = 5,
  parameter int         DISP_DIG = 4,
  parameter logic [7:0] DROP_VEC = 8'h01,
  parameter logic [7:0] DP_VEC   = 8'h05
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [NCH*CODE_W-1:0]       code_i,
  input  logic [NCH*16-1:0]           gain_i,
  input  logic [NCH*16-1:0]           offset_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [NCH*16-1:0]           bin_o,
  output logic [NCH-1:0]              neg_o,
  output logic [NCH-1:0]              ovf_o,
  output logic [NCH*4*DISP_DIG-1:0]   disp_o,
  output logic [NCH*DISP_DIG-1:0]     dat_en_o,
  output logic [NCH*DISP_DIG-1:0]     dot_en_o
);

  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BCD_W  = NIB_W * BCD_DIG;
  localparam int DISP_W = NIB_W * DISP_DIG;

  state_e state_q, state_d;

  logic [CH_W-1:0]         ch_q;
  logic [NCH*CODE_W-1:0]   code_q;
  logic [NCH*LANE_W-1:0]   gain_q;
  logic [NCH*LANE_W-1:0]   off_q;
  logic [LANE_W-1:0]       v_q;
  logic [LANE_W-1:0]       mag_q;
  logic                    sneg_q;

  logic [LANE_W-1:0]       sh_bin_q [NCH];
  logic                    sh_neg_q [NCH];
  logic [BCD_W-1:0]        sh_bcd_q [NCH];

  logic [NCH*LANE_W-1:0]   bin_q;
  logic [NCH-1:0]          neg_q;
  logic [NCH-1:0]          ovf_q;
  logic [NCH*DISP_W-1:0]   disp_q;
  logic [NCH*DISP_DIG-1:0] en_q;
  logic                    done_q;

  logic [CODE_W-1:0]       code_sel;
  logic [LANE_W-1:0]       gain_sel;
  logic [LANE_W-1:0]       off_sel;
  logic [2*LANE_W-1:0]     prod;
  logic [LANE_W-1:0]       mag_d;
  logic                    neg_d;

  logic [BCD_W-1:0]        conv_bcd;
  logic                    conv_last;
  logic                    conv_ready;

  logic                    last_ch;
  logic                    accept;
  logic                    scale_en;
  logic                    load;
  logic                    store_en;
  logic                    fin;

  logic [NCH*LANE_W-1:0]   bin_nx;
  logic [NCH-1:0]          neg_nx;
  logic [NCH-1:0]          ovf_nx;
  logic [NCH*DISP_W-1:0]   disp_nx;
  logic [NCH*DISP_DIG-1:0] en_nx;

  assign last_ch  = (ch_q == CH_W'(NCH - 1));
  assign code_sel = code_q[CODE_W*ch_q +: CODE_W];
  assign gain_sel = gain_q[LANE_W*ch_q +: LANE_W];
  assign off_sel  = off_q[LANE_W*ch_q +: LANE_W];
  assign prod     = (2*LANE_W)'(code_sel) * (2*LANE_W)'(gain_sel);

  // Sign-magnitude of the scaled value; equality counts as positive.
  always_comb begin
    if (v_q >= off_sel) begin
      mag_d = v_q - off_sel;
      neg_d = 1'b0;
    end else begin
      mag_d = off_sel - v_q;
      neg_d = 1'b1;
    end
  end

  bcd_serial_conv #(
    .BIN_W   (BIN_W),
    .BCD_DIG (BCD_DIG)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .mag_i   (BIN_W'(mag_d)),
    .bcd_o   (conv_bcd),
    .last_o  (conv_last),
    .ready_o (conv_ready)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: per channel SCALE, SIGN, CONV, STORE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SCALE;
      ST_SCALE: state_d = ST_SIGN;
      ST_SIGN:  state_d = ST_CONV;
      ST_CONV:  if (conv_last) state_d = ST_STORE;
      ST_STORE: state_d = last_ch ? ST_IDLE : ST_SCALE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes decoded from state.
  always_comb begin
    accept   = 1'b0;
    scale_en = 1'b0;
    load     = 1'b0;
    store_en = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE):  accept   = start_i;
      (state_q == ST_SCALE): scale_en = 1'b1;
      (state_q == ST_SIGN):  load     = 1'b1;
      (state_q == ST_STORE): store_en = conv_ready;
      default: ;
    endcase
  end

  assign fin = store_en & last_ch;

  // Input capture, channel stepping and per-channel shadow results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      code_q <= '0;
      gain_q <= '0;
      off_q  <= '0;
      v_q    <= '0;
      mag_q  <= '0;
      sneg_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        sh_bin_q[c] <= '0;
        sh_neg_q[c] <= 1'b0;
        sh_bcd_q[c] <= '0;
      end
    end else begin
      if (accept) begin
        ch_q   <= '0;
        code_q <= code_i;
        gain_q <= gain_i;
        off_q  <= offset_i;
      end
      if (scale_en) begin
        v_q <= LANE_W'(prod >> LANE_W);
      end
      if (load) begin
        mag_q  <= mag_d;
        sneg_q <= neg_d;
      end
      if (store_en) begin
        sh_bin_q[ch_q] <= mag_q;
        sh_neg_q[ch_q] <= sneg_q;
        sh_bcd_q[ch_q] <= conv_bcd;
        if (!last_ch) ch_q <= ch_q + CH_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam int DROP = int'(DROP_VEC[FLD_W*c +: FLD_W]);
    localparam int DP   = int'(DP_VEC[FLD_W*c +: FLD_W]);

    logic                cur;
    logic [BCD_W-1:0]    bcd_c;
    logic [DISP_W-1:0]   dig_c;
    logic [DISP_W-1:0]   disp_c;
    logic [DISP_DIG-1:0] en_c;
    logic                neg_c;
    logic                ovf_c;
    logic                nz;

    assign cur   = (ch_q == CH_W'(c));
    assign bcd_c = cur ? conv_bcd : sh_bcd_q[c];
    assign neg_c = cur ? sneg_q : sh_neg_q[c];
    assign dig_c = DISP_W'(bcd_c >> (NIB_W * DROP));

    assign bin_nx[LANE_W*c +: LANE_W] = cur ? mag_q : sh_bin_q[c];

    // Leading-zero blanking above the units digit, then the sign overlay.
    always_comb begin
      nz     = 1'b0;
      disp_c = dig_c;
      en_c   = '0;
      for (int k = DISP_DIG - 1; k >= 0; k--) begin
        nz      = nz | (dig_c[NIB_W*k +: NIB_W] != 4'd0);
        en_c[k] = nz | (k <= DP);
      end
      ovf_c = neg_c & (dig_c[DISP_W-1 -: NIB_W] != 4'd0);
      if (neg_c) begin
        disp_c[DISP_W-1 -: NIB_W] = MINUS_GLYPH;
        en_c[DISP_DIG-1]          = 1'b1;
      end
    end

    assign neg_nx[c]                       = neg_c;
    assign ovf_nx[c]                       = ovf_c;
    assign disp_nx[DISP_W*c +: DISP_W]     = disp_c;
    assign en_nx[DISP_DIG*c +: DISP_DIG]   = en_c;
    assign dot_en_o[DISP_DIG*c +: DISP_DIG] = DISP_DIG'(1) << DP;
  end

  // Public results of all channels update together on the final store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      neg_q  <= '0;
      ovf_q  <= '0;
      disp_q <= '0;
      en_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        bin_q  <= bin_nx;
        neg_q  <= neg_nx;
        ovf_q  <= ovf_nx;
        disp_q <= disp_nx;
        en_q   <= en_nx;
      end
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign bin_o    = bin_q;
  assign neg_o    = neg_q;
  assign ovf_o    = ovf_q;
  assign disp_o   = disp_q;
  assign dat_en_o = en_q;

endmodule

// File: tb/tb_ht_scale_bcd_seq.sv
// Randomized bench for ht_scale_bcd_seq against a behavioural model.
// Model: arithmetic scaling, decimal digits by division, fixed latency.
module tb_ht_scale_bcd_seq;

  localparam int LAT = 38;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] code_i = '0;
  logic [31:0] gain_i = '0;
  logic [31:0] offset_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] bin_o;
  logic [1:0]  neg_o;
  logic [1:0]  ovf_o;
  logic [31:0] disp_o;
  logic [7:0]  dat_en_o;
  logic [7:0]  dot_en_o;

  always #5 clk = ~clk;

  ht_scale_bcd_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .code_i   (code_i),
    .gain_i   (gain_i),
    .offset_i (offset_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .bin_o    (bin_o),
    .neg_o    (neg_o),
    .ovf_o    (ovf_o),
    .disp_o   (disp_o),
    .dat_en_o (dat_en_o),
    .dot_en_o (dot_en_o)
  );

  typedef struct packed {
    logic [15:0] bin;
    logic        neg;
    logic        ovf;
    logic [15:0] disp;
    logic [3:0]  en;
  } res_t;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scaled value, sign, decimal digits and display word from plain arithmetic.
  function automatic res_t model(input int unsigned code, input int unsigned gain,
                                 input int unsigned off, input int drop, input int dp);
    res_t        r;
    longint      p;
    int unsigned v;
    int unsigned mag;
    int unsigned val;
    int          d [4];
    bit          nz;
    r   = '0;
    p   = 64'(code) * 64'(gain);
    v   = int'(p >>> 16);
    if (v >= off) begin
      mag   = v - off;
      r.neg = 1'b0;
    end else begin
      mag   = off - v;
      r.neg = 1'b1;
    end
    r.bin = mag[15:0];
    val = mag;
    for (int i = 0; i < drop; i++) val = val / 10;
    for (int k = 0; k < 4; k++) begin
      d[k] = int'(val % 10);
      val  = val / 10;
    end
    nz = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      nz = nz | (d[k] != 0);
      r.en[k] = nz | (k <= dp);
      r.disp[4*k +: 4] = d[k][3:0];
    end
    r.ovf = r.neg & (d[3] != 0);
    if (r.neg) begin
      r.disp[15:12] = 4'hA;
      r.en[3] = 1'b1;
    end
    return r;
  endfunction

  int         rem = 0;
  bit         m_done = 1'b0;
  res_t [1:0] pend = '0;
  res_t [1:0] expv = '0;

  // Reference timeline: accept in idle, results appear LAT edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    = 0;
      m_done = 1'b0;
      expv   = '0;
    end else begin
      m_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_done = 1'b1;
          expv   = pend;
        end
      end else if (start_i) begin
        pend[0] = model(code_i[15:0], gain_i[15:0], offset_i[15:0], 1, 1);
        pend[1] = model(code_i[31:16], gain_i[31:16], offset_i[31:16], 0, 1);
        rem     = LAT;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy_o, rem > 0);
      check("done", done_o, m_done);
      for (int c = 0; c < 2; c++) begin
        check($sformatf("bin%0d", c), bin_o[16*c +: 16], expv[c].bin);
        check($sformatf("neg%0d", c), neg_o[c], expv[c].neg);
        check($sformatf("ovf%0d", c), ovf_o[c], expv[c].ovf);
        check($sformatf("disp%0d", c), disp_o[16*c +: 16], expv[c].disp);
        check($sformatf("en%0d", c), dat_en_o[4*c +: 4], expv[c].en);
      end
      check("dot", dot_en_o, 8'h22);
    end
  end

  // Start one conversion and wait for done; optionally disturb inputs mid-run.
  task automatic run(input logic [31:0] c, input logic [31:0] g,
                     input logic [31:0] o, input bit noise, output int lat);
    code_i   = c;
    gain_i   = g;
    offset_i = o;
    start_i  = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_o) break;
      if (noise) begin
        start_i  = 1'($urandom_range(0, 1));
        code_i   = $urandom;
        gain_i   = $urandom;
        offset_i = $urandom;
      end
    end
    start_i = 1'b0;
    if (!done_o) check("done_timeout", done_o, 1);
  endtask

  int lat;

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_bin", bin_o, 0);
    check("rst_disp", disp_o, 0);
    check("rst_en", dat_en_o, 0);
    check("rst_dot", dot_en_o, 8'h22);

    check("model_t1", model(16'h6666, 17500, 4500, 1, 1),
          {16'd2499, 1'b0, 1'b0, 16'h0249, 4'b0111});
    check("model_t3", model(16'h4000, 17500, 4500, 1, 1),
          {16'd125, 1'b1, 1'b0, 16'hA012, 4'b1011});

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run({16'h8000, 16'h6666}, {16'd1000, 16'd17500}, {16'd0, 16'd4500}, 0, lat);
    check("t1_bin", bin_o[15:0], 2499);
    check("t1_neg", neg_o[0], 0);
    check("t1_disp", disp_o[15:0], 16'h0249);
    check("t1_en", dat_en_o[3:0], 4'b0111);
    check("t1_dot", dot_en_o[3:0], 4'b0010);

    run({16'h8000, 16'h0000}, {16'd1000, 16'd17500}, {16'd0, 16'd4500}, 0, lat);
    check("t2_bin", bin_o[15:0], 4500);
    check("t2_neg", neg_o[0], 1);
    check("t2_disp", disp_o[15:0], 16'hA450);
    check("t2_en", dat_en_o[3:0], 4'b1111);
    check("t2_ovf", ovf_o[0], 0);

    run({16'h8000, 16'h4000}, {16'd1000, 16'd17500}, {16'd0, 16'd4500}, 0, lat);
    check("t3_bin", bin_o[15:0], 125);
    check("t3_neg", neg_o[0], 1);
    check("t3_disp", disp_o[15:0], 16'hA012);
    check("t3_en", dat_en_o[3:0], 4'b1011);

    run({16'h8000, 16'hFFFF}, {16'd1000, 16'd17500}, {16'd0, 16'd4500}, 0, lat);
    check("t4_bin0", bin_o[15:0], 12999);
    check("t4_disp0", disp_o[15:0], 16'h1299);
    check("t4_en0", dat_en_o[3:0], 4'b1111);
    check("t4_bin1", bin_o[31:16], 500);
    check("t4_disp1", disp_o[31:16], 16'h0500);
    check("t4_en1", dat_en_o[7:4], 4'b0111);
    check("t4_dot1", dot_en_o[7:4], 4'b0010);

    run({16'h8000, 16'h6666}, {16'd1000, 16'd17500}, {16'd0, 16'd4500}, 1, lat);
    check("t5_latency", lat, LAT);
    check("t5_bin0", bin_o[15:0], 2499);
    check("t5_bin1", bin_o[31:16], 500);
    @(posedge clk);
    #1 check("t5_done_width", done_o, 0);

    code_i   = {16'h8000, 16'hFFFF};
    gain_i   = {16'd1000, 16'd17500};
    offset_i = {16'd0, 16'd4500};
    start_i  = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (25) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy_o, 0);
    check("t6_done", done_o, 0);
    check("t6_bin", bin_o, 0);
    check("t6_disp", disp_o, 0);
    check("t6_en", dat_en_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run({16'h8000, 16'h6666}, {16'd1000, 16'd17500}, {16'd0, 16'd4500}, 0, lat);
    check("t6_after_bin", bin_o[15:0], 2499);
    check("t6_after_disp", disp_o[15:0], 16'h0249);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] c, g, o;
      c = $urandom;
      for (int h = 0; h < 2; h++) begin
        case ($urandom_range(0, 2))
          0: g[16*h +: 16] = 16'd17500;
          1: g[16*h +: 16] = 16'd1000;
          default: g[16*h +: 16] = 16'($urandom);
        endcase
        case ($urandom_range(0, 2))
          0: o[16*h +: 16] = 16'd4500;
          1: o[16*h +: 16] = 16'd0;
          default: o[16*h +: 16] = 16'($urandom_range(0, 20000));
        endcase
      end
      run(c, g, o, 1'($urandom_range(0, 1)), lat);
      check("rand_latency", lat, LAT);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
